// File: rtl/dump_xmit_pkg.sv
// Shared types and defaults for the capture-RAM dump transmitter.
//   dump_state_t : dump_xmit control states
//   DUMP_*       : default widths and WAIT_DATA abort limit
package dump_xmit_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        WAIT_TX   = 2'd2,
        ACK       = 2'd3
    } dump_state_t;

    localparam int DUMP_DATA_W  = 8;     // RAM read data / UART byte
    localparam int DUMP_CNT_W   = 10;    // holds 0..512 bytes
    localparam int DUMP_TIMEOUT = 4096;  // clk cycles in WAIT_DATA before abort

endpackage

// File: rtl/dump_xmit_if.sv
// Bundle of all dump_xmit handshakes: command processor, capture block and
// UART transmitter.
//   master : dump_xmit side (drives start_dump, dump_sent, trmt, status pulses)
//   slave  : environment side (command processor / capture block / uart_tx)
interface dump_xmit_if import dump_xmit_pkg::*; #(
    parameter int DATA_W = DUMP_DATA_W,
    parameter int CNT_W  = DUMP_CNT_W
) ();
    // command processor
    logic              dump_req;
    logic              capture_done;
    logic              clr_capture_done;
    logic              busy;
    logic              dump_ack;
    logic              dump_nak;
    logic [CNT_W-1:0]  byte_cnt;
    // capture block
    logic              start_dump;
    logic              send_dump;
    logic              dump_sent;
    logic              dump_finished;
    logic [DATA_W-1:0] ram_rdata;
    // uart transmitter
    logic [DATA_W-1:0] tx_data;
    logic              trmt;
    logic              tx_done;

    modport master (
        input  dump_req, capture_done, send_dump, dump_finished, ram_rdata, tx_done,
        output clr_capture_done, busy, dump_ack, dump_nak, byte_cnt,
               start_dump, dump_sent, tx_data, trmt
    );

    modport slave (
        output dump_req, capture_done, send_dump, dump_finished, ram_rdata, tx_done,
        input  clr_capture_done, busy, dump_ack, dump_nak, byte_cnt,
               start_dump, dump_sent, tx_data, trmt
    );
endinterface

// File: rtl/dump_xmit.sv
// Consumer end of the capture-RAM dump handshake.
// Kicks the capture block on a host request, forwards each RAM byte to the
// UART, acknowledges each byte once the UART has shifted it out, and ends on
// dump_finished (ack + clear capture_done) or on a WAIT_DATA timeout (nak).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dump_xmit_if.master (all handshake, data and status signals)
// Every output is a register; pulses last exactly one clk.
module dump_xmit import dump_xmit_pkg::*; #(
    parameter int TIMEOUT = DUMP_TIMEOUT   // must be >= 2
) (
    input  logic          clk,
    input  logic          rst_n,
    dump_xmit_if.master   bus
);

    localparam int             TO_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

    dump_state_t     state;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            to_cnt               <= '0;
            bus.start_dump       <= 1'b0;
            bus.trmt             <= 1'b0;
            bus.dump_sent        <= 1'b0;
            bus.dump_ack         <= 1'b0;
            bus.dump_nak         <= 1'b0;
            bus.clr_capture_done <= 1'b0;
            bus.busy             <= 1'b0;
            bus.tx_data          <= '0;
            bus.byte_cnt         <= '0;
        end else begin
            // pulse outputs default low; each branch raises at most one cycle
            bus.start_dump       <= 1'b0;
            bus.trmt             <= 1'b0;
            bus.dump_sent        <= 1'b0;
            bus.dump_ack         <= 1'b0;
            bus.dump_nak         <= 1'b0;
            bus.clr_capture_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.dump_req) begin
                        if (bus.capture_done) begin
                            bus.start_dump <= 1'b1;
                            bus.byte_cnt   <= '0;
                            bus.busy       <= 1'b1;
                            to_cnt         <= '0;
                            state          <= WAIT_DATA;
                        end else begin
                            bus.dump_nak   <= 1'b1;
                        end
                    end
                end

                WAIT_DATA: begin
                    if (bus.send_dump) begin
                        bus.tx_data <= bus.ram_rdata;
                        bus.trmt    <= 1'b1;
                        state       <= WAIT_TX;
                    end else if (to_cnt == TO_MAX) begin
                        // capture block stalled: abort, leave capture_done set
                        bus.dump_nak <= 1'b1;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                // send_dump stays high here until dump_sent; only tx_done matters
                WAIT_TX: begin
                    if (bus.tx_done) begin
                        bus.dump_sent <= 1'b1;
                        if (bus.byte_cnt != '1)
                            bus.byte_cnt <= bus.byte_cnt + 1'b1;
                        state <= ACK;
                    end
                end

                // dump_sent is high this cycle, so dump_finished is valid now
                ACK: begin
                    if (bus.dump_finished) begin
                        bus.dump_ack         <= 1'b1;
                        bus.clr_capture_done <= 1'b1;
                        bus.busy             <= 1'b0;
                        state                <= IDLE;
                    end else begin
                        to_cnt <= '0;
                        state  <= WAIT_DATA;
                    end
                end

                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
